clock_enable_gen: RTL and testbench
===================================

CLOCK_ENABLE_GEN -- requirements
Module: clock_enable_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of clock-enable channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 8: divisor width per channel.
REQ-003 SHALL have parameter LOCK_CYCLES, default 1024: cycles of continuous lock required before release (>=2).
REQ-004 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for pll_locked (>=2).
REQ-005 SHALL have one clock and asynchronous active-high reset: clock  input  1  sole clock, rising edge.
REQ-006 SHALL have port: reset  input  1  asynchronous, active-high.
REQ-007 SHALL have port: pll_locked  input  1  PLL LOCK, asynchronous to clock.
REQ-008 SHALL have port: div_value  input  NUM_CH*DIV_W  per-channel divisor N, channel k in bits [k*DIV_W +: DIV_W].
REQ-009 SHALL have port: ch_enable  input  NUM_CH  per-channel run enable.
REQ-010 SHALL have port: lock_lost_clr  input  1  clears sticky lock_lost.
REQ-011 SHALL have port: sys_reset  output  1  registered, active-high downstream reset.
REQ-012 SHALL have port: ready  output  1  high only in RUN.
REQ-013 SHALL have port: tick  output  NUM_CH  single-cycle enable pulses.
REQ-014 SHALL have port: lock_lost  output  1  sticky lock-loss flag.

Function
REQ-015 SHALL pass pll_locked through a SYNC_STAGES flop chain; all logic uses the synchronised value lk.
REQ-016 SHALL implement FSM WAIT_LOCK, STABILIZE, RUN.
REQ-017 WAIT_LOCK: sys_reset=1, ready=0; lk=1 -> STABILIZE with stability counter cleared.
REQ-018 STABILIZE: counter increments each cycle; lk=0 -> WAIT_LOCK; counter==LOCK_CYCLES-1 with lk=1 -> RUN.
REQ-019 RUN: sys_reset=0 and ready=1, registered, first asserted the cycle after the RUN transition.
REQ-020 Stability counter width SHALL be $clog2(LOCK_CYCLES) and SHALL never wrap.
REQ-021 Each channel SHALL hold a counter 0..N-1; tick[k]=1 for exactly one cycle when counter==N-1, counter then returns to 0.
REQ-022 N=0 and N=1 SHALL both give tick every cycle; N=2^DIV_W-1 gives period 2^DIV_W-1.
REQ-023 Divisor SHALL be latched at enable rise and at each wrap; mid-period changes take effect at the next period.
REQ-024 First tick after ch_enable rises (in RUN) SHALL occur N cycles later (counter starts at 0 on rise cycle+1).
REQ-025 ch_enable=0 or state!=RUN SHALL hold counter at 0 and tick at 0 in the same cycle.
REQ-026 lock_lost_clr and a new loss event in the same cycle: set wins.

Reset
REQ-027 reset SHALL asynchronously force: state WAIT_LOCK, synchroniser 0, all counters 0, sys_reset=1, ready=0, tick=0, lock_lost=0.
REQ-028 reset mid-RUN SHALL abort all channels immediately; release restarts full lock qualification.

Configuration
REQ-029 Macro CLOCK_ENABLE_GEN_LOSS_DETECT_EN defined: lk=0 in RUN SHALL go to WAIT_LOCK, assert sys_reset next cycle, set lock_lost until lock_lost_clr.
REQ-030 Macro undefined: lk=0 in RUN SHALL be ignored (stay RUN); lock_lost tied 0; lock_lost_clr unused.

Structure
REQ-031 Shared package clock_enable_gen_pkg SHALL hold the FSM state enum and a clog2-based width function.
REQ-032 Per-channel divider SHALL be sub-module clock_enable_div, instantiated NUM_CH times by generate.

Verification
REQ-033 LOCK_CYCLES=16, SYNC_STAGES=2: pll_locked rises at cycle 0 -> STABILIZE entered cycle 2, ready=1 and sys_reset=0 at cycle 19.
REQ-034 pll_locked glitches low for 3 cycles at STABILIZE count 10 -> return to WAIT_LOCK, ready stays 0, full 16-cycle count restarts.
REQ-035 RUN, N=4, ch_enable rises -> tick at cycles 4, 8, 12; change N to 2 at cycle 6 -> next ticks at 8, 10, 12.
REQ-036 N=0 and N=1 -> tick high every cycle; N=255 -> period 255.
REQ-037 Macro defined, pll_locked drops in RUN -> ready=0, sys_reset=1, ticks stop, lock_lost=1 until lock_lost_clr; macro undefined -> ready stays 1.
REQ-038 Async reset asserted mid-RUN between clock edges -> all outputs at reset values before next edge.

Source files
------------

// File: rtl/clock_enable_gen_pkg.sv
// Shared types and helpers for the clock-enable generator: FSM state
// encoding and the width function for the lock-stability counter.
package clock_enable_gen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2
  } state_t;

  // Minimum of one bit so that small counts still give a legal vector.
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clock_enable_div.sv
// One clock-enable channel: counts 0..N-1 while active and pulses tick on
// the last count. The divisor is latched on start-up and at every wrap.
module clock_enable_div
  import clock_enable_gen_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             active,
  input  logic [DIV_W-1:0] div_value,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] last;
  logic             started;
  logic             wrap;

  // N=0 and N=1 both collapse to a single-state counter.
  assign last = (div_q <= DIV_W'(1)) ? '0 : div_q - DIV_W'(1);
  assign wrap = (cnt == last);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      div_q   <= '0;
      started <= 1'b0;
    end else if (!active) begin
      cnt     <= '0;
      started <= 1'b0;
    end else if (!started) begin
      started <= 1'b1;
      cnt     <= '0;
      div_q   <= div_value;
    end else if (wrap) begin
      cnt     <= '0;
      div_q   <= div_value;
    end else begin
      cnt     <= cnt + DIV_W'(1);
    end
  end

  // Gated combinationally so that a disable or a loss of RUN kills the
  // pulse in the same cycle; the stale divisor is never used before start.
  assign tick = active & started & wrap;

endmodule

// File: rtl/clock_enable_gen.sv
// Lock-qualified reset sequencer with NUM_CH clock-enable dividers.
// Define CLOCK_ENABLE_GEN_LOSS_DETECT_EN to drop out of RUN on lock loss.
module clock_enable_gen
  import clock_enable_gen_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pll_locked,
  input  logic [NUM_CH*DIV_W-1:0] div_value,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic                    lock_lost_clr,
  output logic                    sys_reset,
  output logic                    ready,
  output logic [NUM_CH-1:0]       tick,
  output logic                    lock_lost
);

  localparam int              CNT_W    = cnt_width(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       stab_cnt, cnt_d;
  logic                   run;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end
  assign lk = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= WAIT_LOCK;
      stab_cnt <= '0;
    end else begin
      state_q  <= state_d;
      stab_cnt <= cnt_d;
    end
  end

  // NOTE: defaults first so no path through the case leaves a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      WAIT_LOCK: if (lk) state_d = STABILIZE;
      STABILIZE: begin
        if (!lk)                    state_d = WAIT_LOCK;
        else if (stab_cnt == CNT_LAST) state_d = RUN;
        else                        cnt_d   = stab_cnt + CNT_W'(1);
      end
      RUN: begin
`ifdef CLOCK_ENABLE_GEN_LOSS_DETECT_EN
        if (!lk) state_d = WAIT_LOCK;
`endif
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  assign run = (state_q == RUN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sys_reset <= 1'b1;
      ready     <= 1'b0;
    end else begin
      sys_reset <= !run;
      ready     <= run;
    end
  end

`ifdef CLOCK_ENABLE_GEN_LOSS_DETECT_EN
  // A fresh loss event outranks a simultaneous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)              lock_lost <= 1'b0;
    else if (run && !lk)    lock_lost <= 1'b1;
    else if (lock_lost_clr) lock_lost <= 1'b0;
  end
`else
  logic unused_lock_lost_clr;
  assign unused_lock_lost_clr = lock_lost_clr;
  assign lock_lost            = 1'b0;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clock_enable_div #(.DIV_W(DIV_W)) u_div (
      .clock     (clock),
      .reset     (reset),
      .active    (ch_enable[k] & run),
      .div_value (div_value[k*DIV_W +: DIV_W]),
      .tick      (tick[k])
    );
  end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed bench for clock_enable_gen: lock qualification, divider ticks
// via an expected-tick queue, lock loss and asynchronous reset.
module tb_clock_enable_gen;

  localparam int NUM_CH      = 2;
  localparam int DIV_W       = 8;
  localparam int LOCK_CYCLES = 16;
  localparam int SYNC_STAGES = 2;

`ifdef CLOCK_ENABLE_GEN_LOSS_DETECT_EN
  localparam bit LOSS = 1'b1;
`else
  localparam bit LOSS = 1'b0;
`endif

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic                    pll_locked = 1'b0;
  logic [NUM_CH*DIV_W-1:0] div_value = '0;
  logic [NUM_CH-1:0]       ch_enable = '0;
  logic                    lock_lost_clr = 1'b0;
  logic                    sys_reset, ready, lock_lost;
  logic [NUM_CH-1:0]       tick;

  int vectors = 0;
  int errors  = 0;
  int sb[$];
  int first;

  clock_enable_gen #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W),
    .LOCK_CYCLES(LOCK_CYCLES), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clock(clock), .reset(reset), .pll_locked(pll_locked),
    .div_value(div_value), .ch_enable(ch_enable),
    .lock_lost_clr(lock_lost_clr), .sys_reset(sys_reset),
    .ready(ready), .tick(tick), .lock_lost(lock_lost)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Raises pll_locked ahead of edge 0; returns the first edge index after
  // which ready reads 1, or -1 if it never does within the budget.
  task automatic lock_first_ready(input bit glitch, output int first_k);
    first_k    = -1;
    pll_locked = 1'b1;
    for (int k = 0; k < 60 && first_k < 0; k++) begin
      @(posedge clock);
      #1;
      if (ready) first_k = k;
      if (glitch && k == 10) pll_locked = 1'b0;
      if (glitch && k == 13) pll_locked = 1'b1;
    end
  endtask

  // Channel ch was just enabled in this cycle (cycle 0); sb holds expected
  // tick cycles. Optionally rewrites a divisor during cycle chg_at.
  task automatic run_window(input int ch, input int ncyc, input int chg_at,
                            input logic [DIV_W-1:0] chg_div);
    logic [NUM_CH-1:0] exp_tick;
    #1;
    check("tick_at_enable", 32'(tick), 0);
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clock);
      #1;
      exp_tick = '0;
      if (sb.size() > 0 && sb[0] == c) begin
        exp_tick[ch] = 1'b1;
        void'(sb.pop_front());
      end
      check($sformatf("tick_ch%0d_c%0d", ch, c), 32'(tick), 32'(exp_tick));
      if (c == chg_at) div_value[ch*DIV_W +: DIV_W] = chg_div;
    end
    check("sb_drain", sb.size(), 0);
    sb.delete();
    ch_enable = '0;
    #1;
    check("tick_off_same_cycle", 32'(tick), 0);
    step(2);
  endtask

  initial begin
    // Reset state
    step(3);
    check("rst_sys_reset", sys_reset, 1);
    check("rst_ready", ready, 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_lock_lost", lock_lost, 0);

    reset = 1'b0;
    step(5);
    check("nolock_ready", ready, 0);
    check("nolock_sys_reset", sys_reset, 1);

    // Clean qualification
    lock_first_ready(1'b0, first);
    check("qual_first_ready", first, 19);
    check("qual_sys_reset", sys_reset, 0);

    // Glitch during STABILIZE restarts the count
    reset = 1'b1;
    pll_locked = 1'b0;
    step(3);
    reset = 1'b0;
    step(2);
    lock_first_ready(1'b1, first);
    check("glitch_first_ready", first, 33);

    // N=4 with change to 2 mid-period
    div_value[0 +: DIV_W] = 8'd4;
    ch_enable = 2'b01;
    sb = '{4, 8, 10, 12, 14};
    run_window(0, 15, 6, 8'd2);

    // N=0 on channel 1
    div_value[DIV_W +: DIV_W] = 8'd0;
    ch_enable = 2'b10;
    sb = '{1, 2, 3, 4, 5, 6};
    run_window(1, 6, -1, 8'd0);

    // N=1 on channel 0
    div_value[0 +: DIV_W] = 8'd1;
    ch_enable = 2'b01;
    sb = '{1, 2, 3, 4, 5, 6};
    run_window(0, 6, -1, 8'd0);

    // N=255
    div_value[0 +: DIV_W] = 8'd255;
    ch_enable = 2'b01;
    sb = '{255, 510};
    run_window(0, 511, -1, 8'd0);

    // Lock loss in RUN
    div_value[0 +: DIV_W] = 8'd1;
    ch_enable = 2'b01;
    step(2);
    check("pre_loss_tick", 32'(tick), 1);
    pll_locked = 1'b0;
    step(3);
    check("loss_tick", 32'(tick), LOSS ? 0 : 1);
    check("loss_flag", lock_lost, 32'(LOSS));
    step(1);
    check("loss_ready", ready, LOSS ? 0 : 1);
    check("loss_sys_reset", sys_reset, 32'(LOSS));
    step(3);
    check("loss_sticky", lock_lost, 32'(LOSS));
    lock_lost_clr = 1'b1;
    step(1);
    lock_lost_clr = 1'b0;
    check("loss_cleared", lock_lost, 0);

    // Relock, then loss and clear together: set wins
    lock_first_ready(1'b0, first);
    check("relock_first_ready", first, LOSS ? 19 : 0);
    lock_lost_clr = 1'b1;
    pll_locked = 1'b0;
    step(3);
    check("set_wins", lock_lost, 32'(LOSS));
    lock_lost_clr = 1'b0;
    lock_first_ready(1'b0, first);
    check("relock2_first_ready", first, LOSS ? 19 : 0);

    // Asynchronous reset between edges, mid-RUN
    step(3);
    check("pre_areset_tick", 32'(tick), 1);
    check("pre_areset_ready", ready, 1);
    #2;
    reset = 1'b1;
    #1;
    check("areset_sys_reset", sys_reset, 1);
    check("areset_ready", ready, 0);
    check("areset_tick", 32'(tick), 0);
    check("areset_lock_lost", lock_lost, 0);
    step(1);
    reset = 1'b0;
    lock_first_ready(1'b0, first);
    check("areset_requal", first, 19);
    check("areset_tick_resume", 32'(tick), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
